// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared types and constants for the boot program loader
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } ldr_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int CSUM_W         = 8;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/word_packer.sv
// rtl/word_packer.sv - assembles little-endian words from bytes and keeps the running byte sum
module word_packer
    import prog_loader_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic [7:0]                  byte_in,
    input  logic                        byte_vld,
    output logic [8*BYTES_PER_WORD-1:0] word_out,
    output logic                        word_vld,
    output logic [CSUM_W-1:0]           sum,
    output logic [LANE_W-1:0]           lane
);

    localparam int                ASM_W     = 8 * (BYTES_PER_WORD - 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

    logic [ASM_W-1:0] asm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q    <= '0;
            word_out <= '0;
            word_vld <= 1'b0;
            sum      <= '0;
            lane     <= '0;
        end else begin
            word_vld <= 1'b0;
            if (clear) begin
                asm_q <= '0;
                sum   <= '0;
                lane  <= '0;
            end else if (byte_vld) begin
                sum  <= sum + byte_in;
                lane <= lane + LANE_W'(1);
                // Top lane completes the word; lower lanes are parked until then.
                if (lane == LAST_LANE) begin
                    word_out <= {byte_in, asm_q};
                    word_vld <= 1'b1;
                end else begin
                    asm_q[{lane, 3'b000} +: 8] <= byte_in;
                end
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream program loader holding the core in reset until verified
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int MAX_WORDS  = 1024,
    parameter bit AUTO_START = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              error
);

    localparam ldr_state_t  RESET_STATE = AUTO_START ? ST_LEN_LO : ST_IDLE;
    localparam logic [15:0] MAX_N       = 16'(MAX_WORDS);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

    ldr_state_t        state_q, state_d;
    logic [15:0]       n_q;
    logic [15:0]       n_hdr;
    logic [ADDR_W-1:0] widx_q;
    logic              hs;
    logic              restart;
    logic              pk_clear;
    logic              last_word;
    logic              word_vld;
    logic [31:0]       word_out;
    logic [CSUM_W-1:0] sum;
    logic [LANE_W-1:0] lane;

    assign in_ready  = state_q inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM};
    assign hs        = in_valid & in_ready;
    assign n_hdr     = {in_data, n_q[7:0]};
    assign last_word = (32'(widx_q) + 32'd1) == 32'(n_q);

    always_comb begin
        state_d  = state_q;
        restart  = 1'b0;
        pk_clear = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d  = ST_LEN_LO;
                    restart  = 1'b1;
                    pk_clear = 1'b1;
                end
            end
            ST_LEN_LO: if (hs) state_d = ST_LEN_HI;
            ST_LEN_HI: begin
                if (hs) begin
                    pk_clear = 1'b1;
                    if (n_hdr > MAX_N)       state_d = ST_ERR;
                    else if (n_hdr == 16'd0) state_d = ST_CSUM;
                    else                     state_d = ST_DATA;
                end
            end
            ST_DATA: if (hs && lane == LAST_LANE && last_word) state_d = ST_CSUM;
            ST_CSUM: if (hs) state_d = (in_data == sum) ? ST_DONE : ST_ERR;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_STATE;
            n_q     <= '0;
            widx_q  <= '0;
        end else begin
            state_q <= state_d;
            if (restart)
                n_q <= '0;
            else if (state_q == ST_LEN_LO && hs)
                n_q[7:0] <= in_data;
            else if (state_q == ST_LEN_HI && hs)
                n_q[15:8] <= in_data;
            // Index advances after the write so mem_addr is stable during the strobe.
            if (pk_clear)
                widx_q <= '0;
            else if (word_vld)
                widx_q <= widx_q + ADDR_W'(1);
        end
    end

    word_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .clear    (pk_clear),
        .byte_in  (in_data),
        .byte_vld (hs && state_q == ST_DATA),
        .word_out (word_out),
        .word_vld (word_vld),
        .sum      (sum),
        .lane     (lane)
    );

    assign mem_we    = word_vld;
    assign mem_addr  = widx_q;
    assign mem_wdata = word_out;
    assign core_rst  = state_q != ST_DONE;
    assign done      = state_q == ST_DONE;
    assign error     = state_q == ST_ERR;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_rst;
    logic              done;
    logic              error;

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int hs_cyc    = 0;
    int first_cyc = 0;

    int          wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          l3_cyc[$];

    logic [31:0] prog [8] = '{32'h00a00093, 32'h01400113, 32'h01900193, 32'h00208233,
                              32'h003202b3, 32'h00526333, 32'h00000393, 32'h005273b3};

    prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(1024), .AUTO_START(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_rst  (core_rst),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr.push_back(int'(mem_addr));
            wr_data.push_back(mem_wdata);
            wr_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        l3_cyc.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int   tmo;
        logic acc;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
        in_data  = b;
        in_valid = 1'b1;
        acc      = 1'b0;
        tmo      = 0;
        while (!acc && tmo < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            tmo++;
        end
        if (!acc) check("hs_timeout", {31'd0, in_ready}, 32'd1);
        hs_cyc = cyc;
    endtask

    task automatic pulse_start();
        in_valid = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [7:0] csum_adj, input bit gaps, input int poke);
        logic [7:0] cs;
        logic [7:0] b;
        int         g;
        int         bi;
        cs = 8'd0;
        bi = 0;
        clear_log();
        send_byte(n[7:0], 0);
        first_cyc = hs_cyc;
        send_byte(n[15:8], 0);
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                if (bi == poke) pulse_start();
                b  = prog[w][8*k +: 8];
                cs = cs + b;
                g  = gaps ? int'($urandom_range(0, 1)) : 0;
                send_byte(b, g);
                if (k == 3) l3_cyc.push_back(hs_cyc);
                bi++;
            end
        end
        check("done_before_csum", {31'd0, done}, 32'd0);
        send_byte(cs + csum_adj, 0);
        in_valid = 1'b0;
    endtask

    task automatic check_writes(input string tag, input int n);
        check({tag, "_wr_count"}, 32'(wr_addr.size()), 32'(n));
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            check({tag, "_wr_addr"}, 32'(wr_addr[i]), 32'(i));
            check({tag, "_wr_data"}, wr_data[i], prog[i]);
            if (i < l3_cyc.size())
                check({tag, "_wr_latency"}, 32'(wr_cyc[i]), 32'(l3_cyc[i]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_core_rst"}, {31'd0, core_rst}, 32'd1);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // good frame, back-to-back
        send_frame(8, 8'd0, 1'b0, -1);
        check_writes("good", 8);
        check("good_done", {31'd0, done}, 32'd1);
        check("good_core_rst", {31'd0, core_rst}, 32'd0);
        check("good_error", {31'd0, error}, 32'd0);
        check("good_in_ready", {31'd0, in_ready}, 32'd0);
        check("good_frame_time", 32'(hs_cyc - first_cyc), 32'd34);

        // restart from DONE, then bad checksum
        pulse_start();
        check("restart_core_rst", {31'd0, core_rst}, 32'd1);
        check("restart_done", {31'd0, done}, 32'd0);
        check("restart_in_ready", {31'd0, in_ready}, 32'd1);
        send_frame(8, 8'd1, 1'b0, -1);
        check_writes("badcs", 8);
        check("badcs_error", {31'd0, error}, 32'd1);
        check("badcs_done", {31'd0, done}, 32'd0);
        check("badcs_core_rst", {31'd0, core_rst}, 32'd1);
        check("badcs_in_ready", {31'd0, in_ready}, 32'd0);

        // empty frames
        pulse_start();
        send_frame(0, 8'd0, 1'b0, -1);
        check("n0_writes", 32'(wr_addr.size()), 32'd0);
        check("n0_done", {31'd0, done}, 32'd1);
        check("n0_error", {31'd0, error}, 32'd0);
        pulse_start();
        send_frame(0, 8'd1, 1'b0, -1);
        check("n0bad_error", {31'd0, error}, 32'd1);
        check("n0bad_done", {31'd0, done}, 32'd0);

        // oversize header
        pulse_start();
        clear_log();
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        check("big_error", {31'd0, error}, 32'd1);
        check("big_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("big_no_consume", {31'd0, in_ready}, 32'd0);
        check("big_error_held", {31'd0, error}, 32'd1);
        check("big_writes", 32'(wr_addr.size()), 32'd0);
        in_valid = 1'b0;

        // gappy in_valid
        pulse_start();
        send_frame(8, 8'd0, 1'b1, -1);
        check_writes("gaps", 8);
        check("gaps_done", {31'd0, done}, 32'd1);

        // reset mid-load after two words
        pulse_start();
        clear_log();
        send_byte(8'h08, 0);
        send_byte(8'h00, 0);
        for (int w = 0; w < 2; w++)
            for (int k = 0; k < 4; k++)
                send_byte(prog[w][8*k +: 8], 0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_writes", 32'(wr_addr.size()), 32'd2);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_frame(8, 8'd0, 1'b0, -1);
        check_writes("reload", 8);
        check("reload_done", {31'd0, done}, 32'd1);

        // start in DONE restarts; start mid-DATA is ignored
        pulse_start();
        check("restart2_core_rst", {31'd0, core_rst}, 32'd1);
        check("restart2_done", {31'd0, done}, 32'd0);
        send_frame(8, 8'd0, 1'b0, 6);
        check_writes("midstart", 8);
        check("midstart_done", {31'd0, done}, 32'd1);
        check("midstart_error", {31'd0, error}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
